// File: rtl/load_store_unit.sv
// Load/store unit: accepts RISC-V style B/H/W requests and drives a byte-addressed memory.
// Sub-word stores are done as read-modify-write of the containing word.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_op,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_w,
    input  logic [DATA_WIDTH-1:0] mem_data_r
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_SIZE - 4);

    state_t                  state;
    logic                    we_q;
    logic [2:0]              funct3_q;
    logic [15:0]             wdata_q;
    logic                    accept;
    logic                    illegal;
    logic                    out_of_range;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [DATA_WIDTH-1:0]   merged_data;

    assign accept       = req_valid && req_ready;
    assign out_of_range = req_addr > MAX_ADDR;

    always_comb begin
        illegal = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            3'b100, 3'b101:         illegal = req_we;
            default:                illegal = 1'b0;
        endcase
    end

    // Extension of the captured word for loads, and sub-word merge for B/H stores.
    always_comb begin
        load_data = mem_data_r;
        case (funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){mem_data_r[7]}}, mem_data_r[7:0]};
            3'b001:  load_data = {{(DATA_WIDTH-16){mem_data_r[15]}}, mem_data_r[15:0]};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, mem_data_r[7:0]};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, mem_data_r[15:0]};
            default: load_data = mem_data_r;
        endcase
    end

    always_comb begin
        if (funct3_q == 3'b000)
            merged_data = {mem_data_r[DATA_WIDTH-1:8], wdata_q[7:0]};
        else
            merged_data = {mem_data_r[DATA_WIDTH-1:16], wdata_q[15:0]};
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_op     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_data_w <= '0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            wdata_q    <= '0;
        end else begin
            mem_op <= 1'b0;
            mem_rw <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        wdata_q   <= req_wdata[15:0];
                        mem_addr  <= req_addr;
                        if (illegal || out_of_range) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we && req_funct3 == 3'b010) begin
                            state      <= WRITE;
                            mem_op     <= 1'b1;
                            mem_rw     <= 1'b1;
                            mem_data_w <= req_wdata;
                        end else begin
                            state  <= READ;
                            mem_op <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        state      <= WRITE;
                        mem_op     <= 1'b1;
                        mem_rw     <= 1'b1;
                        mem_data_w <= merged_data;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: begin
                    // Ready rises on the handshake edge so the next request can follow one edge later.
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed memory model plus
// a scoreboard queue of expected responses.
module tb_load_store_unit;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_op;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_w;
    logic [31:0] mem_data_r;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    bit          mem_loaded = 1'b0;
    logic [7:0]  mem [0:1023];

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(1024)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_op(mem_op), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_data_w(mem_data_w), .mem_data_r(mem_data_r)
    );

    always #5 sys_clk = ~sys_clk;

    // Memory model: combinational read, write on the edge where op/rw are seen.
    always_comb begin
        mem_data_r = 32'h0;
        if (mem_addr <= 32'd1020)
            mem_data_r = {mem[mem_addr + 3], mem[mem_addr + 2], mem[mem_addr + 1], mem[mem_addr]};
    end

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            mem[0] <= 8'h37; mem[1] <= 8'h05; mem[2] <= 8'h00; mem[3] <= 8'hF0;
            mem[256] <= 8'h44; mem[257] <= 8'h33; mem[258] <= 8'h22; mem[259] <= 8'h11;
            mem[1020] <= 8'h01; mem[1021] <= 8'h02; mem[1022] <= 8'h03; mem[1023] <= 8'h04;
            mem_loaded <= 1'b1;
        end else if (mem_op) begin
            if (mem_rw) begin
                wr_pulses <= wr_pulses + 1;
                if (mem_addr <= 32'd1020) begin
                    mem[mem_addr]     <= mem_data_w[7:0];
                    mem[mem_addr + 1] <= mem_data_w[15:8];
                    mem[mem_addr + 2] <= mem_data_w[23:16];
                    mem[mem_addr + 3] <= mem_data_w[31:24];
                end
            end else begin
                rd_pulses <= rd_pulses + 1;
            end
        end
    end

    // Push the expectation, run one request/response with resp_ready high.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int acc_cyc);
        int n;
        sb.push_back('{exp_rdata, exp_err, exp_lat});
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL accept_timeout: req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
            rdata = 'x; err = 1'bx; lat = -1; acc_cyc = cyc;
            return;
        end
        @(negedge sys_clk);
        acc_cyc = cyc;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(negedge sys_clk);
            lat++;
        end
        rdata = resp_rdata;
        err = resp_err;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        repeat (4) @(negedge sys_clk);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req_ready: got %b want 0", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (mem_op !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_op: got %b want 0", mem_op); end
        n_checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_resp: got err=%b rdata=%h want 0/0", resp_err, resp_rdata); end
        req_valid = 1'b0;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [6] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ad  [6] = '{32'h0, 32'h3, 32'h3, 32'h2, 32'h2, 32'h1};
        logic [31:0] ex  [6] = '{32'hF0000537, 32'hFFFFFFF0, 32'h000000F0,
                                 32'hFFFFF000, 32'h0000F000, 32'h00F00005};
        logic [31:0] rdata; logic err; int lat, acc, rd0, wr0;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            rd0 = rd_pulses; wr0 = wr_pulses;
            send(1'b0, f3[i], ad[i], 32'h0, ex[i], 1'b0, 2, rdata, err, lat, acc);
            e = sb.pop_front();
            n_checks++; if (rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL load%0d_rdata: got %h want %h", i, rdata, e.rdata); end
            n_checks++; if (err !== e.err) begin n_fail++; $display("[TB] FAIL load%0d_err: got %b want %b", i, err, e.err); end
            n_checks++; if (lat !== e.lat) begin n_fail++; $display("[TB] FAIL load%0d_latency: got %0d want %0d", i, lat, e.lat); end
            n_checks++; if (rd_pulses - rd0 !== 1 || wr_pulses - wr0 !== 0) begin n_fail++; $display("[TB] FAIL load%0d_pulses: got rd=%0d wr=%0d want 1/0", i, rd_pulses - rd0, wr_pulses - wr0); end
        end
    endtask

    task automatic test_stores();
        // SB at 0x100, SW at 0x200, unaligned SH at 0x201; each followed by LW readback.
        logic [2:0]  f3  [3] = '{3'b000, 3'b010, 3'b001};
        logic [31:0] ad  [3] = '{32'h100, 32'h200, 32'h201};
        logic [31:0] wd  [3] = '{32'h000000AB, 32'hDEADBEEF, 32'h1234CAFE};
        logic [31:0] rb  [3] = '{32'h112233AB, 32'hDEADBEEF, 32'hDECAFEEF};
        int          lt  [3] = '{3, 2, 3};
        int          rp  [3] = '{1, 0, 1};
        logic [31:0] rb_ad [3] = '{32'h100, 32'h200, 32'h200};
        logic [31:0] rdata; logic err; int lat, acc, rd0, wr0;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            rd0 = rd_pulses; wr0 = wr_pulses;
            send(1'b1, f3[i], ad[i], wd[i], 32'h0, 1'b0, lt[i], rdata, err, lat, acc);
            e = sb.pop_front();
            n_checks++; if (rdata !== e.rdata || err !== e.err) begin n_fail++; $display("[TB] FAIL store%0d_resp: got rdata=%h err=%b want %h/%b", i, rdata, err, e.rdata, e.err); end
            n_checks++; if (lat !== e.lat) begin n_fail++; $display("[TB] FAIL store%0d_latency: got %0d want %0d", i, lat, e.lat); end
            n_checks++; if (rd_pulses - rd0 !== rp[i] || wr_pulses - wr0 !== 1) begin n_fail++; $display("[TB] FAIL store%0d_pulses: got rd=%0d wr=%0d want %0d/1", i, rd_pulses - rd0, wr_pulses - wr0, rp[i]); end
            send(1'b0, 3'b010, rb_ad[i], 32'h0, rb[i], 1'b0, 2, rdata, err, lat, acc);
            e = sb.pop_front();
            n_checks++; if (rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL store%0d_readback: got %h want %h", i, rdata, e.rdata); end
        end
    endtask

    task automatic test_errors();
        logic        we  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3  [4] = '{3'b010, 3'b100, 3'b011, 3'b010};
        logic [31:0] ad  [4] = '{32'h3FD, 32'h10, 32'h10, 32'h3FC};
        logic        ee  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ex  [4] = '{32'h0, 32'h0, 32'h0, 32'h04030201};
        int          lt  [4] = '{1, 1, 1, 2};
        logic [31:0] rdata; logic err; int lat, acc, rd0, wr0;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            rd0 = rd_pulses; wr0 = wr_pulses;
            send(we[i], f3[i], ad[i], 32'h55AA55AA, ex[i], ee[i], lt[i], rdata, err, lat, acc);
            e = sb.pop_front();
            n_checks++; if (err !== e.err || rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL err%0d_resp: got err=%b rdata=%h want %b/%h", i, err, rdata, e.err, e.rdata); end
            n_checks++; if (lat !== e.lat) begin n_fail++; $display("[TB] FAIL err%0d_latency: got %0d want %0d", i, lat, e.lat); end
            n_checks++; if ((rd_pulses - rd0) + (wr_pulses - wr0) !== (ee[i] ? 0 : 1)) begin n_fail++; $display("[TB] FAIL err%0d_pulses: got %0d want %0d", i, (rd_pulses - rd0) + (wr_pulses - wr0), ee[i] ? 0 : 1); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held; int n;
        exp_t e;
        sb.push_back('{32'hF0000537, 1'b0, 2});
        sb.push_back('{32'hFFFFFFF0, 1'b0, 2});
        resp_ready = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge sys_clk); n++; end
        @(negedge sys_clk);
        req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin @(negedge sys_clk); n++; end
        e = sb.pop_front();
        held = resp_rdata;
        n_checks++; if (held !== e.rdata) begin n_fail++; $display("[TB] FAIL bp_rdata: got %h want %h", held, e.rdata); end
        req_funct3 = 3'b000; req_addr = 32'h3; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || req_ready !== 1'b0) begin
                n_fail++; $display("[TB] FAIL bp_hold%0d: got valid=%b rdata=%h ready=%b want 1/%h/0", i, resp_valid, resp_rdata, req_ready, e.rdata);
            end
        end
        resp_ready = 1'b1;
        @(negedge sys_clk);
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_handshake: got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
        @(negedge sys_clk);
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_second_accept: got ready=%b want 0", req_ready); end
        n = 1;
        while (resp_valid !== 1'b1 && n < 20) begin @(negedge sys_clk); n++; end
        e = sb.pop_front();
        n_checks++; if (resp_rdata !== e.rdata || n !== e.lat) begin n_fail++; $display("[TB] FAIL bp_second_resp: got %h lat=%0d want %h lat=%0d", resp_rdata, n, e.rdata, e.lat); end
        @(negedge sys_clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdata; logic err; int lat, acc0, acc1, acc2;
        exp_t e;
        send(1'b0, 3'b010, 32'h0, 32'h0, 32'hF0000537, 1'b0, 2, rdata, err, lat, acc0);
        e = sb.pop_front();
        send(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2, rdata, err, lat, acc1);
        e = sb.pop_front();
        send(1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2, rdata, err, lat, acc2);
        e = sb.pop_front();
        n_checks++; if (rdata !== e.rdata) begin n_fail++; $display("[TB] FAIL b2b_readback: got %h want %h", rdata, e.rdata); end
        n_checks++; if (acc1 - acc0 !== 3 || acc2 - acc1 !== 3) begin n_fail++; $display("[TB] FAIL b2b_spacing: got %0d/%0d want 3/3", acc1 - acc0, acc2 - acc1); end
    endtask

    task automatic test_reset_in_write();
        int n;
        resp_ready = 1'b1;
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge sys_clk); n++; end
        @(negedge sys_clk);
        req_valid = 1'b0;
        n_checks++; if (mem_op !== 1'b1 || mem_rw !== 1'b1) begin n_fail++; $display("[TB] FAIL rw_in_write: got op=%b rw=%b want 1/1", mem_op, mem_rw); end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        n_checks++; if (mem_op !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rw_abort: got op=%b valid=%b ready=%b want 0/0/0", mem_op, resp_valid, req_ready);
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rw_release: got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
        @(negedge sys_clk);
        n_checks++; if (resp_valid !== 1'b0 || mem_op !== 1'b0) begin n_fail++; $display("[TB] FAIL rw_no_resp: got valid=%b op=%b want 0/0", resp_valid, mem_op); end
    endtask

    initial begin
        sys_rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        @(negedge sys_clk);
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_in_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
